// File: rtl/mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_select_arbiter
// Description : Round-robin owner arbiter for a shared mux slice, with a
//               one-cycle turnaround between owners. Optional grant timeout
//               enabled by defining ARB_GRANT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_select_arbiter #(
    parameter int BITS_ENABLES = 2,
    parameter int NUM_REQ      = 2**BITS_ENABLES,
    parameter int MAX_HOLD     = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [NUM_REQ-1:0]      i_req,
    output logic [NUM_REQ-1:0]      o_grant,
    output logic [BITS_ENABLES-1:0] o_sel,
    output logic                    o_busy,
    output logic                    o_preempt
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANT   = 2'd1;
    localparam logic [1:0] c_HANDOFF = 2'd2;

    localparam logic [NUM_REQ-1:0]      c_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [BITS_ENABLES-1:0] c_LAST_RST = BITS_ENABLES'(NUM_REQ - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > (2**BITS_ENABLES) || MAX_HOLD < 2) begin : g_bad_params
            $error("mux_select_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      w_grant_nxt;
    logic [BITS_ENABLES-1:0] r_sel;
    logic [BITS_ENABLES-1:0] w_sel_nxt;
    logic [BITS_ENABLES-1:0] r_last;
    logic [BITS_ENABLES-1:0] w_last_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;

    logic [BITS_ENABLES-1:0] w_winner;
    logic [BITS_ENABLES-1:0] w_idx;
    logic [NUM_REQ-1:0]      w_onehot;
    logic                    w_any_req;
    logic                    w_owner_req;
    logic                    w_timeout;

    assign w_any_req   = |i_req;
    // In GRANT r_grant is the owner's one-hot, so masking avoids a variable index.
    assign w_owner_req = |(i_req & r_grant);

    // Scan downward so the candidate closest after r_last is written last and wins.
    always_comb begin : p_arbiter
        w_winner = r_last;
        w_idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = BITS_ENABLES'((int'(r_last) + i) % NUM_REQ);
            if (i_req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    assign w_onehot = c_ONE << w_winner;

`ifdef ARB_GRANT_TIMEOUT_EN
    localparam int                    c_HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_MAX = c_HOLD_W'(MAX_HOLD - 1);

    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                r_preempt;
    logic                w_preempt_nxt;
    logic                w_others_req;

    assign w_others_req  = |(i_req & ~r_grant);
    assign w_timeout     = (r_hold == c_HOLD_MAX) && w_others_req;
    // A simultaneous release is an ordinary handoff, not a revocation.
    assign w_preempt_nxt = (r_state == c_GRANT) && w_owner_req && w_timeout;

    // Counter sits at zero outside GRANT, so it starts fresh on every entry.
    always_comb begin : p_hold
        w_hold_nxt = r_hold;
        if (r_state != c_GRANT) begin
            w_hold_nxt = '0;
        end else if (r_hold != c_HOLD_MAX) begin
            w_hold_nxt = r_hold + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin : p_hold_reg
        if (!i_reset_n) begin
            r_hold    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    assign o_preempt = r_preempt;
`else
    assign w_timeout = 1'b0;
    assign o_preempt = 1'b0;
`endif

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_last_nxt  = r_last;
        case (r_state)
            c_GRANT: begin
                if (!w_owner_req || w_timeout) begin
                    w_state_nxt = c_HANDOFF;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                // IDLE and HANDOFF arbitrate identically; o_sel only moves here.
                if (w_any_req) begin
                    w_state_nxt = c_GRANT;
                    w_grant_nxt = w_onehot;
                    w_sel_nxt   = w_winner;
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = w_winner;
                end else begin
                    w_state_nxt = c_IDLE;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin : p_state_reg
        if (!i_reset_n) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_last  <= c_LAST_RST;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign o_grant = r_grant;
    assign o_sel   = r_sel;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_select_arbiter
// Description : Scoreboard bench for mux_select_arbiter against an
//               owner/rotation reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_select_arbiter;

    localparam int BE = 2;
    localparam int N  = 4;
    localparam int MH = 4;
`ifdef ARB_GRANT_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  o_grant;
    logic [BE-1:0] o_sel;
    logic          o_busy;
    logic          o_preempt;

    always #5 clk = ~clk;

    mux_select_arbiter #(
        .BITS_ENABLES (BE),
        .NUM_REQ      (N),
        .MAX_HOLD     (MH)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_req     (req),
        .o_grant   (o_grant),
        .o_sel     (o_sel),
        .o_busy    (o_busy),
        .o_preempt (o_preempt)
    );

    typedef struct {
        int            cyc;
        logic [N-1:0]  grant;
        logic [BE-1:0] sel;
        logic          busy;
        logic          preempt;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: who owns the slice (-1 = nobody), rotation pointer, hold age.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_pre   = 1'b0;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_sel   = 0;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    function automatic exp_t model_out(int c);
        exp_t e;
        e.cyc   = c;
        e.grant = '0;
        if (m_owner >= 0) e.grant[m_owner] = 1'b1;
        e.sel     = BE'(m_sel);
        e.busy    = (m_owner >= 0);
        e.preempt = m_pre;
        return e;
    endfunction

    task automatic model_edge(input logic [N-1:0] r);
        int others;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            others = 0;
            for (int k = 0; k < N; k++) if (k != m_owner && r[k]) others++;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (TIMEOUT_ON && m_hold == MH - 1 && others > 0) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end else if (r != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (r[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    break;
                end
            end
            m_last = m_owner;
            m_sel  = m_owner;
            m_hold = 0;
        end
    endtask

    // Called at posedge+1: drive, record expectation for after the next edge, advance.
    task automatic step(input logic [N-1:0] r);
        req = r;
        model_edge(r);
        q.push_back(model_out(cyc + 1));
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step();
        model_reset();
        q.push_back(model_out(cyc + 1));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc != cyc || o_grant !== e.grant || o_sel !== e.sel ||
                o_busy !== e.busy || o_preempt !== e.preempt) begin
                bad++;
                $display("FAIL outputs cyc=%0d/%0d: got grant=%b sel=%0d busy=%b preempt=%b, want grant=%b sel=%0d busy=%b preempt=%b",
                         cyc, e.cyc, o_grant, o_sel, o_busy, o_preempt,
                         e.grant, e.sel, e.busy, e.preempt);
            end
        end
    end

    initial begin : stim
        logic [N-1:0] r;
        logic [N-1:0] done;
        @(posedge clk);
        #1;
        repeat (2) rst_step();
        rst_n = 1'b1;

        // single requester, then release into idle with o_sel retained
        repeat (3) step(4'b0100);
        repeat (3) step(4'b0000);
        // late request pulse while 0 owns
        repeat (3) step(4'b0001);
        step(4'b0101);
        repeat (2) step(4'b0001);
        repeat (2) step(4'b0000);
        // rotation from last=1 with 3 and 0 pending
        repeat (3) step(4'b0010);
        repeat (4) step(4'b1001);
        repeat (3) step(4'b0001);
        repeat (2) step(4'b0000);
        // long hold with a competitor waiting
        repeat (2) step(4'b0001);
        repeat (12) step(4'b0011);
        repeat (2) step(4'b0000);

        // asynchronous reset between edges while 2 owns
        repeat (3) step(4'b0100);
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        q.push_back(model_out(cyc));
        q.push_back(model_out(cyc + 1));
        @(posedge clk);
        #1;
        rst_step();
        rst_n = 1'b1;

        // all request; each owner drops two cycles after its grant
        done = '0;
        repeat (16) begin
            r = 4'b1111 & ~done;
            if (m_owner >= 0 && m_hold == 1) begin
                r[m_owner]    = 1'b0;
                done[m_owner] = 1'b1;
            end
            step(r);
        end
        repeat (2) step(4'b0000);

        // randomized traffic; owners hold for a random span
        r = '0;
        repeat (800) begin
            for (int i = 0; i < N; i++) begin
                if (i == m_owner) r[i] = ($urandom_range(0, 5) != 0);
                else if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
            end
            if ($urandom_range(0, 30) == 0) r = '0;
            step(r);
        end
        step(4'b0000);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_select_arbiter.md
Name: mux_select_arbiter

Overview:
Round-robin arbiter that shares one `mux`-style datapath slice between NUM_REQ requesters, for example a memory or register-bank port contended by pipeline stages and the debug unit.
- Samples level-held requests and grants ownership to one requester.
- Drives the mux select index `o_sel` (feeds `i_en` of the mux) plus a one-hot grant.
- Inserts one turnaround cycle between owners so the shared bus never switches combinationally under a live transfer.

Parameters:
- BITS_ENABLES, 2, width of the select index.
- NUM_REQ, 2**BITS_ENABLES, number of requesters; must be ≥2 and equal the mux slice count.
- MAX_HOLD, 16, maximum consecutive GRANT cycles before preemption; used only with ARB_GRANT_TIMEOUT_EN; must be ≥2.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester request, level; held high for the whole ownership.
- o_grant  out  NUM_REQ  one-hot grant, registered; all zero when no owner.
- o_sel  out  BITS_ENABLES  index of current or last owner; drives mux `i_en`.
- o_busy  out  1  high while in GRANT.
- o_preempt  out  1  one-cycle pulse when the owner is forcibly revoked.

Behaviour:
- All outputs are registered. Reset asserts asynchronously, releases synchronously to i_clock by the surrounding reset logic.
- Reset values:
  - state = IDLE
  - o_grant = 0, o_sel = 0, o_busy = 0, o_preempt = 0
  - internal last-winner pointer `last` = NUM_REQ-1, so requester 0 has first priority
  - hold counter = 0
- States: IDLE, GRANT, HANDOFF.
- Arbitration function, evaluated in IDLE and HANDOFF:
  - winner = first set bit of i_req scanning last+1, last+2, … wrapping modulo NUM_REQ, ending with last itself.
  - No request set: stay or go to IDLE.
- IDLE:
  - On a clock edge with any i_req set: go to GRANT.
  - On that same edge: o_grant = onehot(winner), o_sel = winner, o_busy = 1, last = winner.
  - Latency: request seen at edge N, grant visible after edge N (one cycle after request assertion).
- GRANT:
  - i_req[owner] = 1: stay; o_grant and o_sel stable.
  - i_req[owner] = 0 sampled: go to HANDOFF; o_grant = 0, o_busy = 0, o_sel holds the old value.
  - Other requests do not affect the current owner.
- HANDOFF:
  - Exactly one cycle.
  - Any request pending: arbitrate and go to GRANT (same updates as IDLE).
  - No request pending: go to IDLE.
  - Minimum gap between two grants = one cycle with o_grant = 0.
- o_sel changes only on entry to GRANT; it is never altered in IDLE or HANDOFF.
- A requester dropping i_req before being granted is simply not considered.
- Simultaneous requests are resolved purely by rotation; no requester waits more than NUM_REQ-1 ownerships.
- o_grant is never multi-hot; o_grant is nonzero if and only if o_busy = 1.
- Asynchronous reset mid-GRANT returns all outputs to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ARB_GRANT_TIMEOUT_EN
- Defined:
  - A hold counter clears on GRANT entry and increments each GRANT cycle.
  - When the count reaches MAX_HOLD-1 while any other requester is pending: go to HANDOFF on that edge as if the owner released, and assert o_preempt for exactly that one cycle.
  - If only the owner requests, the counter saturates and no preemption occurs.
  - A preempted owner still holding i_req competes normally; rotation places it last.
- Undefined:
  - No counter logic is present.
  - o_preempt is tied to 0.
  - Ownership ends only by release.

Test Plan:
- Single requester: reset, then i_req = 0100 from edge 1 → after edge 1, o_grant = 0100, o_sel = 2, o_busy = 1. Drop i_req → o_grant = 0 next cycle, then IDLE with o_sel still 2.
- Simultaneous requests: i_req = 1111 from reset; each owner drops its bit two cycles after its grant → grant order 0, 1, 2, 3, with exactly one zero-grant cycle between each.
- Rotation: last = 1; owner 1 releases while i_req = 1001 → next grant is 3, then 0.
- Late and withdrawn request: i_req[2] pulses for one cycle while owner 0 holds → no grant to 2; owner 0 is kept with o_grant unchanged.
- Timeout (ARB_GRANT_TIMEOUT_EN, MAX_HOLD = 4): i_req[0] held, i_req[1] raised → after 4 GRANT cycles, o_preempt = 1 for one cycle and o_grant = 0; then o_grant = 0010, o_sel = 1. Without the macro, 0 is held indefinitely.
- Async reset: assert i_reset_n = 0 mid-GRANT between clock edges → o_grant, o_sel, o_busy, o_preempt go to 0 immediately. After release, requester 0 wins first.
